// File: rtl/frame_stream_reader_pkg.sv
// Shared constants and FSM encoding for the frame-buffer to AXI4-Stream reader.
// The widths and frame geometry here are the defaults for a 640x480 RGB444 frame.
package frame_stream_reader_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIXELS   = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 12;

    localparam logic [ADDR_W-1:0] LAST_PIXEL = 19'h4AFFF;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic state_is_busy(state_e s);
        return (s == ST_READ) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/frame_stream_reader_if.sv
// Frame-buffer read port plus AXI4-Stream video master, bundled for the reader.
// master = reader side, slave = memory/downstream side.
interface frame_stream_reader_if #(
    parameter int DATA_W = frame_stream_reader_pkg::DATA_W,
    parameter int ADDR_W = frame_stream_reader_pkg::ADDR_W
) ();

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // A beat transfers on a clock edge where m_tvalid and m_tready are both 1.
    // Once m_tvalid rises, m_tdata/m_tuser/m_tlast and m_tvalid itself hold
    // until that transfer; m_tvalid never depends on m_tready in the same cycle.
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tuser;
    logic              m_tlast;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output m_tdata, m_tvalid, m_tuser, m_tlast,
        input  m_tready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  m_tdata, m_tvalid, m_tuser, m_tlast,
        output m_tready
    );

endinterface

// File: rtl/frame_stream_reader_fifo.sv
// Four-entry synchronous FIFO carrying pixel data plus its tuser/tlast tags.
// flush empties it in one clock; push and pop in the same clock keep count.
module frame_stream_reader_fifo
    import frame_stream_reader_pkg::*;
#(
    parameter int W = DATA_W + 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [W-1:0]          head_data,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  empty,
    output logic                  full
);

    logic [W-1:0]          mem_q [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
    assign do_pop    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + FIFO_CNT_W'(1);
                2'b01:   count_q <= count_q - FIFO_CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once count says so.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // The read-issue throttle upstream keeps at most three beats in flight.
    overflow_a: assert property (@(posedge clk) disable iff (!resetn)
        !(push && full && !do_pop && !flush));

endmodule

// File: rtl/frame_stream_reader.sv
// Reads one frame from a synchronous frame-buffer RAM in raster order and emits
// it as an AXI4-Stream video master with tuser on pixel 0 and tlast per line.
module frame_stream_reader #(
    parameter int H_ACTIVE   = frame_stream_reader_pkg::H_ACTIVE,
    parameter int V_ACTIVE   = frame_stream_reader_pkg::V_ACTIVE,
    parameter int DATA_W     = frame_stream_reader_pkg::DATA_W,
    parameter int ADDR_W     = frame_stream_reader_pkg::ADDR_W,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         sync_rst,
    input  logic                         start,
    frame_stream_reader_if.master        bus,
    output logic                         busy,
    output logic                         frame_done,
    output logic [1:0]                   dbg_state
);

    import frame_stream_reader_pkg::*;

    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam int TAG_W = DATA_W + 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    state_e            state_q;
    logic              busy_q;
    logic              frame_done_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic              inflight_q;
    logic              tag_user_q;
    logic              tag_last_q;

    logic                  rd_en;
    logic                  last_issue;
    logic                  last_pop;
    logic                  pop;
    logic [TAG_W-1:0]      fifo_head;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Issue is throttled by registered occupancy only, so no path from tready.
    assign rd_en = (state_q == ST_READ) && !fifo_full &&
                   (({1'b0, fifo_count} + 4'(inflight_q)) <= 4'd2);
    assign last_issue = rd_en && (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign pop        = bus.m_tvalid && bus.m_tready;
    // In DRAIN nothing new is issued, so the lone remaining beat is the last.
    assign last_pop   = pop && (state_q == ST_DRAIN) && !inflight_q &&
                        (fifo_count == FIFO_CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_addr_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            inflight_q   <= 1'b0;
            tag_user_q   <= 1'b0;
            tag_last_q   <= 1'b0;
        end else if (sync_rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_addr_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            inflight_q   <= 1'b0;
            tag_user_q   <= 1'b0;
            tag_last_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            inflight_q   <= rd_en;
            tag_user_q   <= (rd_addr_q == '0);
            tag_last_q   <= (col_q == COL_LAST);
            if (rd_en) begin
                if (last_issue) begin
                    rd_addr_q <= '0;
                    col_q     <= '0;
                    row_q     <= '0;
                end else begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        row_q <= row_q + ROW_W'(1);
                    end else begin
                        col_q <= col_q + COL_W'(1);
                    end
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_READ;
                        busy_q    <= 1'b1;
                        rd_addr_q <= '0;
                        col_q     <= '0;
                        row_q     <= '0;
                    end
                end
                ST_READ: begin
                    if (last_issue) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state_q      <= ST_DONE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (CONTINUOUS) begin
                        state_q   <= ST_READ;
                        busy_q    <= 1'b1;
                        rd_addr_q <= '0;
                        col_q     <= '0;
                        row_q     <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    frame_stream_reader_fifo #(
        .W(TAG_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (sync_rst),
        .push      (inflight_q),
        .push_data ({tag_user_q, tag_last_q, bus.mem_rdata}),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Payload is forced to zero while empty so reset leaves every output low.
    assign bus.mem_rd_en = rd_en;
    assign bus.mem_addr  = rd_addr_q;
    assign bus.m_tvalid  = !fifo_empty;
    assign bus.m_tdata   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    assign bus.m_tuser   = !fifo_empty && fifo_head[DATA_W+1];
    assign bus.m_tlast   = !fifo_empty && fifo_head[DATA_W];

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader on a reduced 8x4 frame plus a 4x2 continuous
// instance; expected beats come from a raster-order model of the frame buffer.
module tb_frame_stream_reader;

    localparam int H      = 8;
    localparam int V      = 4;
    localparam int PIX    = H * V;
    localparam int H2     = 4;
    localparam int V2     = 2;
    localparam int PIX2   = H2 * V2;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 19;
    localparam int EXP_W  = DATA_W + 3;
    localparam int LIMIT  = 2000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       sync_rst;
    logic       start;
    logic       start2;
    logic       busy, busy2;
    logic       frame_done, frame_done2;
    logic [1:0] dbg_state, dbg_state2;

    int checks   = 0;
    int failures = 0;
    int issued   = 0;
    int acc      = 0;
    int k2       = 0;
    int mode     = 0;

    logic [DATA_W-1:0] mem  [PIX];
    logic [DATA_W-1:0] mem2 [PIX2];
    logic [EXP_W-1:0]  exp_q [$];

    frame_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    frame_stream_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

    frame_stream_reader #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CONTINUOUS(1'b0)
    ) dut (
        .clk(clk), .resetn(resetn), .sync_rst(sync_rst), .start(start), .bus(bus),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    frame_stream_reader #(
        .H_ACTIVE(H2), .V_ACTIVE(V2), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CONTINUOUS(1'b1)
    ) dut2 (
        .clk(clk), .resetn(resetn), .sync_rst(1'b0), .start(start2), .bus(bus2),
        .busy(busy2), .frame_done(frame_done2), .dbg_state(dbg_state2)
    );

    // ---------------- clock / memory models ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rdata <= (int'(bus.mem_addr) < PIX) ? mem[int'(bus.mem_addr)] : 'x;
        if (bus2.mem_rd_en)
            bus2.mem_rdata <= (int'(bus2.mem_addr) < PIX2) ? mem2[int'(bus2.mem_addr)] : 'x;
    end

    initial begin
        bus.m_tready  = 1'b1;
        bus2.m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       bus.m_tready = 1'b1;
                1:       bus.m_tready = 1'($urandom_range(0, 1));
                default: bus.m_tready = 1'b0;
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < PIX; i++) mem[i] = DATA_W'($urandom);
    endtask

    // Reference model: raster order, tuser on pixel 0, tlast on column H-1.
    task automatic start_frame(input bit timed);
        int n;
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int i = 0; i < PIX; i++)
            exp_q.push_back({i == PIX - 1, i == 0, (i % H) == H - 1, mem[i]});
        @(posedge clk);
        #1;
        start = 1'b0;
        if (timed) begin
            @(negedge clk);
            check("first_rd_en", bus.mem_rd_en, 1);
            check("first_addr", bus.mem_addr, 0);
            n = 1;
            while (!frame_done && n < LIMIT) begin
                @(negedge clk);
                n++;
            end
            check("frame_done_latency", n, PIX + 3);
        end
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc < target && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, acc >= target, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < LIMIT);
        check(name, frame_done, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, bus.m_tvalid, 0);
        check({tag, "_tdata"}, bus.m_tdata, 0);
        check({tag, "_tuser"}, bus.m_tuser, 0);
        check({tag, "_tlast"}, bus.m_tlast, 0);
        check({tag, "_rd_en"}, bus.mem_rd_en, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- scoreboard monitor (main instance) ----------------
    initial begin : monitor
        logic [EXP_W-1:0]  e;
        logic [DATA_W+1:0] prev;
        logic [DATA_W+1:0] cur;
        bit stall_prev;
        bit done_pend;
        int post_rst;
        stall_prev = 0;
        done_pend  = 0;
        post_rst   = 0;
        prev       = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                exp_q.delete();
                stall_prev = 0;
                done_pend  = 0;
                post_rst   = 0;
                issued     = 0;
                acc        = 0;
            end else begin
                cur = {bus.m_tuser, bus.m_tlast, bus.m_tdata};
                check("frame_done_pulse", frame_done, done_pend);
                done_pend = 0;
                if (post_rst > 0) begin
                    check("tvalid_after_sync_rst", bus.m_tvalid, 0);
                    post_rst--;
                end
                if (stall_prev) begin
                    check("hold_tvalid", bus.m_tvalid, 1);
                    check("hold_payload", cur, prev);
                end
                if (bus.mem_rd_en) begin
                    check("rd_addr", bus.mem_addr, issued % PIX);
                    issued++;
                end
                if (bus.m_tvalid && bus.m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", cur, e[DATA_W+1:0]);
                        done_pend = e[EXP_W-1];
                    end
                    acc++;
                end
                check("reads_ahead", (issued - acc) <= 4, 1);
                stall_prev = bus.m_tvalid && !bus.m_tready;
                prev = cur;
                if (sync_rst) begin
                    exp_q.delete();
                    done_pend  = 0;
                    stall_prev = 0;
                    post_rst   = 2;
                    issued     = 0;
                    acc        = 0;
                end
            end
        end
    end

    // ---------------- continuous-mode monitor ----------------
    initial begin : cont_monitor
        int cyc;
        int last_cyc;
        logic [DATA_W+1:0] e2;
        cyc      = 0;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (resetn && k2 < 3 * PIX2 && bus2.m_tvalid && bus2.m_tready) begin
                e2 = {(k2 % PIX2) == 0, (k2 % H2) == H2 - 1, mem2[k2 % PIX2]};
                check("cont_beat", {bus2.m_tuser, bus2.m_tlast, bus2.m_tdata}, e2);
                if (k2 > 0) check("cont_gap", cyc - last_cyc, ((k2 % PIX2) == 0) ? 4 : 1);
                last_cyc = cyc;
                k2++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int target;
        int issues;
        int late;
        int n;
        void'($urandom(32'h5EED_0042));
        resetn   = 1'b0;
        sync_rst = 1'b0;
        start    = 1'b0;
        start2   = 1'b0;
        fill_mem();
        for (int i = 0; i < PIX2; i++) mem2[i] = DATA_W'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset");

        // continuous instance runs alongside the first frame
        @(posedge clk);
        #1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;

        // full frame, tready held high
        mode = 0;
        start_frame(1);

        // random back-pressure
        fill_mem();
        mode = 1;
        start_frame(0);
        wait_done("random_frame_done");

        // long stall mid-line
        fill_mem();
        mode = 0;
        start_frame(0);
        wait_acc(acc + 13, "stall_reach");
        mode   = 2;
        issues = 0;
        late   = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.mem_rd_en) begin
                issues++;
                if (i >= 10) late++;
            end
        end
        check("stall_issue_bound", issues <= 3, 1);
        check("stall_rd_quiet", late, 0);
        check("stall_tvalid", bus.m_tvalid, 1);
        mode = 0;
        wait_done("stall_frame_done");

        // sync_rst mid-frame, then a clean restart
        fill_mem();
        mode = 1;
        start_frame(0);
        wait_acc(acc + 20, "abort_reach");
        @(posedge clk);
        #1;
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        repeat (5) @(negedge clk);
        fill_mem();
        mode = 0;
        start_frame(0);
        wait_done("restart_frame_done");

        // start while busy and during DONE must be ignored
        fill_mem();
        mode = 1;
        start_frame(0);
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid_frame", busy, 1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busy_start_frame_done");
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = 0;
        repeat (10) @(negedge clk);
        check("ignored_start_tvalid", bus.m_tvalid, 0);
        check("ignored_start_busy", busy, 0);
        check("ignored_start_exp_left", exp_q.size(), 0);

        // asynchronous reset mid-frame clears outputs at once
        fill_mem();
        start_frame(0);
        wait_acc(acc + 5, "areset_reach");
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        fill_mem();
        start_frame(1);

        n = 0;
        while (k2 < 3 * PIX2 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("cont_beats_seen", k2 >= 3 * PIX2, 1);
        repeat (5) @(negedge clk);
        check("final_exp_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
